// File: rtl/div_pipe_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// div_pipe_scheduler_pkg
// Purpose : shared defaults for the divider scheduler slice. Operand and
//           result widths match the divider pipeline's length definitions.
//           PIPE_LAT_DEF tracks the current depth of that pipeline.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package div_pipe_scheduler_pkg;

  localparam int N_REQ_DEF    = 4;
  localparam int DD_W_DEF     = 16;
  localparam int DV_W_DEF     = 8;
  localparam int Q_W_DEF      = 16;
  localparam int PIPE_LAT_DEF = 7;

  // Width of a requester id. Kept at least 1 bit so a single-requester
  // build still has a legal vector.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_tag_pipe.sv
// ---------------------------------------------------------------------------
// div_tag_pipe
// Purpose : DEPTH-deep shift register of {valid, id} that runs beside the
//           divider pipeline. A tag entering on the cycle an op is issued
//           leaves on the cycle the divider presents that op's result.
// Ports   : clk        - clock, rising edge
//           reset      - asynchronous, active-high; empties the pipe
//           in_valid   - issue strobe for the op entering this cycle
//           in_id      - owner of the op entering this cycle
//           exit_valid - last stage holds a live tag
//           exit_id    - owner recorded in the last stage
// ---------------------------------------------------------------------------
module div_tag_pipe
  import div_pipe_scheduler_pkg::*;
#(
  parameter int DEPTH = PIPE_LAT_DEF,
  parameter int ID_W  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [ID_W-1:0] in_id,
  output logic            exit_valid,
  output logic [ID_W-1:0] exit_id
);

  logic [DEPTH-1:0] valid_q;
  logic [ID_W-1:0]  id_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        id_q[k] <= '0;
      end
    end else begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        valid_q[k] <= valid_q[k-1];
        id_q[k]    <= id_q[k-1];
      end
      valid_q[0] <= in_valid;
      id_q[0]    <= in_id;
    end
  end

  assign exit_valid = valid_q[DEPTH-1];
  assign exit_id    = id_q[DEPTH-1];

endmodule

// File: rtl/div_pipe_scheduler.sv
// ---------------------------------------------------------------------------
// div_pipe_scheduler
// Purpose : shares one pipelined divider (one issue per cycle, fixed
//           latency PIPE_LAT) among N_REQ requesters. Round-robin grants,
//           one outstanding op per requester, results routed back by tag.
// Ports   : clk, reset            - clock / async active-high reset
//           req, req_dividend,
//           req_divisor           - per-requester request and packed operands
//           ack                   - one-cycle grant pulse (operands consumed)
//           rsp_valid             - one-cycle one-hot result pulse
//           rsp_quotient/remainder/div_zero - last result, held
//           in_flight             - ops issued and not yet returned
//           err_tag               - sticky tag/pipe_done disagreement
//           pipe_go/dividend/divisor - registered issue to the divider
//           pipe_done/quotient/remainder/dv_nzero - divider last stage
// ---------------------------------------------------------------------------
module div_pipe_scheduler
  import div_pipe_scheduler_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int DD_W     = DD_W_DEF,
  parameter int DV_W     = DV_W_DEF,
  parameter int Q_W      = Q_W_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_REQ-1:0]                req,
  input  logic [N_REQ*DD_W-1:0]           req_dividend,
  input  logic [N_REQ*DV_W-1:0]           req_divisor,
  output logic [N_REQ-1:0]                ack,
  output logic [N_REQ-1:0]                rsp_valid,
  output logic [Q_W-1:0]                  rsp_quotient,
  output logic [DD_W-1:0]                 rsp_remainder,
  output logic                            rsp_div_zero,
  output logic [$clog2(PIPE_LAT+1)-1:0]   in_flight,
  output logic                            err_tag,
  output logic                            pipe_go,
  output logic [DD_W-1:0]                 pipe_dividend,
  output logic [DV_W-1:0]                 pipe_divisor,
  input  logic                            pipe_done,
  input  logic [Q_W-1:0]                  pipe_quotient,
  input  logic [DD_W-1:0]                 pipe_remainder,
  input  logic                            pipe_dv_nzero
);

  localparam int ID_W  = id_width(N_REQ);
  localparam int CNT_W = $clog2(PIPE_LAT + 1);

  logic [N_REQ-1:0] ack_q, ack_d;
  logic [N_REQ-1:0] busy_q, busy_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             pipe_go_q, pipe_go_d;
  logic [DD_W-1:0]  pipe_dividend_q, pipe_dividend_d;
  logic [DV_W-1:0]  pipe_divisor_q, pipe_divisor_d;
  logic [ID_W-1:0]  issue_id_q, issue_id_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [Q_W-1:0]   rsp_quotient_q, rsp_quotient_d;
  logic [DD_W-1:0]  rsp_remainder_q, rsp_remainder_d;
  logic             rsp_div_zero_q, rsp_div_zero_d;
  logic [CNT_W-1:0] in_flight_q, in_flight_d;
  logic             err_tag_q, err_tag_d;

  logic             exit_valid;
  logic [ID_W-1:0]  exit_id;

  // The ack term blocks a second grant on the cycle the requester is
  // still holding req after its grant pulse.
  logic [N_REQ-1:0] eligible;
  genvar gi;
  for (gi = 0; gi < N_REQ; gi++) begin : g_elig
    assign eligible[gi] = req[gi] & ~busy_q[gi] & ~ack_q[gi];
  end

  // Round-robin: scan upward from the pointer, first eligible wins.
  logic            grant_found;
  logic [ID_W-1:0] grant_id;
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!grant_found && eligible[(int'(ptr_q) + k) % N_REQ]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  // Tags are loaded from the registered issue so they enter on the cycle
  // pipe_go is high, which lines the exit up with pipe_done.
  div_tag_pipe #(
    .DEPTH (PIPE_LAT),
    .ID_W  (ID_W)
  ) u_tag_pipe (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (pipe_go_q),
    .in_id      (issue_id_q),
    .exit_valid (exit_valid),
    .exit_id    (exit_id)
  );

  always_comb begin
    ack_d           = '0;
    busy_d          = busy_q;
    ptr_d           = ptr_q;
    pipe_go_d       = grant_found;
    pipe_dividend_d = pipe_dividend_q;
    pipe_divisor_d  = pipe_divisor_q;
    issue_id_d      = issue_id_q;
    rsp_valid_d     = '0;
    rsp_quotient_d  = rsp_quotient_q;
    rsp_remainder_d = rsp_remainder_q;
    rsp_div_zero_d  = rsp_div_zero_q;
    in_flight_d     = in_flight_q;
    err_tag_d       = err_tag_q;

    // Retirement. A busy owner is never eligible, so the grant below can
    // never touch the same busy bit on the same edge.
    if (exit_valid) begin
      busy_d[exit_id] = 1'b0;
      if (pipe_done) begin
        rsp_valid_d[exit_id] = 1'b1;
        rsp_quotient_d       = pipe_quotient;
        rsp_remainder_d      = pipe_remainder;
        rsp_div_zero_d       = ~pipe_dv_nzero;
      end else begin
        err_tag_d = 1'b1;
      end
    end else if (pipe_done) begin
      err_tag_d = 1'b1;
    end

    if (grant_found) begin
      ack_d[grant_id]  = 1'b1;
      busy_d[grant_id] = 1'b1;
      pipe_dividend_d  = req_dividend[grant_id*DD_W +: DD_W];
      pipe_divisor_d   = req_divisor[grant_id*DV_W +: DV_W];
      issue_id_d       = grant_id;
      ptr_d            = ID_W'((int'(grant_id) + 1) % N_REQ);
    end

    // Counts tag-pipe occupancy, so it is bounded by PIPE_LAT.
    case ({pipe_go_q, exit_valid})
      2'b10:   in_flight_d = in_flight_q + CNT_W'(1);
      2'b01:   in_flight_d = in_flight_q - CNT_W'(1);
      default: in_flight_d = in_flight_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q           <= '0;
      busy_q          <= '0;
      ptr_q           <= '0;
      pipe_go_q       <= 1'b0;
      pipe_dividend_q <= '0;
      pipe_divisor_q  <= '0;
      issue_id_q      <= '0;
      rsp_valid_q     <= '0;
      rsp_quotient_q  <= '0;
      rsp_remainder_q <= '0;
      rsp_div_zero_q  <= 1'b0;
      in_flight_q     <= '0;
      err_tag_q       <= 1'b0;
    end else begin
      ack_q           <= ack_d;
      busy_q          <= busy_d;
      ptr_q           <= ptr_d;
      pipe_go_q       <= pipe_go_d;
      pipe_dividend_q <= pipe_dividend_d;
      pipe_divisor_q  <= pipe_divisor_d;
      issue_id_q      <= issue_id_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_quotient_q  <= rsp_quotient_d;
      rsp_remainder_q <= rsp_remainder_d;
      rsp_div_zero_q  <= rsp_div_zero_d;
      in_flight_q     <= in_flight_d;
      err_tag_q       <= err_tag_d;
    end
  end

  assign ack           = ack_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_quotient  = rsp_quotient_q;
  assign rsp_remainder = rsp_remainder_q;
  assign rsp_div_zero  = rsp_div_zero_q;
  assign in_flight     = in_flight_q;
  assign err_tag       = err_tag_q;
  assign pipe_go       = pipe_go_q;
  assign pipe_dividend = pipe_dividend_q;
  assign pipe_divisor  = pipe_divisor_q;

endmodule

// File: tb/tb_div_pipe_scheduler.sv
// ---------------------------------------------------------------------------
// tb_div_pipe_scheduler
// Purpose : directed bench for div_pipe_scheduler with a behavioural
//           PIPE_LAT-deep divider attached to the pipe_* ports.
// ---------------------------------------------------------------------------
module tb_div_pipe_scheduler;

  localparam int N   = 4;
  localparam int DDW = 16;
  localparam int DVW = 8;
  localparam int QW  = 16;
  localparam int LAT = 7;
  localparam int CW  = $clog2(LAT + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     req = '0;
  logic [N*DDW-1:0] req_dividend = '0;
  logic [N*DVW-1:0] req_divisor = '0;
  logic [N-1:0]     ack, rsp_valid;
  logic [QW-1:0]    rsp_quotient;
  logic [DDW-1:0]   rsp_remainder;
  logic             rsp_div_zero;
  logic [CW-1:0]    in_flight;
  logic             err_tag;
  logic             pipe_go;
  logic [DDW-1:0]   pipe_dividend;
  logic [DVW-1:0]   pipe_divisor;
  logic             pipe_done;
  logic [QW-1:0]    pipe_quotient;
  logic [DDW-1:0]   pipe_remainder;
  logic             pipe_dv_nzero;

  always #5 clk = ~clk;

  div_pipe_scheduler #(
    .N_REQ(N), .DD_W(DDW), .DV_W(DVW), .Q_W(QW), .PIPE_LAT(LAT)
  ) dut (
    .clk(clk), .reset(reset), .req(req),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .ack(ack), .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient),
    .rsp_remainder(rsp_remainder), .rsp_div_zero(rsp_div_zero),
    .in_flight(in_flight), .err_tag(err_tag),
    .pipe_go(pipe_go), .pipe_dividend(pipe_dividend), .pipe_divisor(pipe_divisor),
    .pipe_done(pipe_done), .pipe_quotient(pipe_quotient),
    .pipe_remainder(pipe_remainder), .pipe_dv_nzero(pipe_dv_nzero)
  );

  // Behavioural divider: result of an op issued in cycle t appears in t+LAT.
  logic            m_go [LAT];
  logic [QW-1:0]   m_q  [LAT];
  logic [DDW-1:0]  m_r  [LAT];
  logic            m_nz [LAT];
  logic            force_done = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < LAT; k++) m_go[k] <= 1'b0;
    end else begin
      for (int k = LAT - 1; k > 0; k--) begin
        m_go[k] <= m_go[k-1]; m_q[k] <= m_q[k-1];
        m_r[k]  <= m_r[k-1];  m_nz[k] <= m_nz[k-1];
      end
      m_go[0] <= pipe_go;
      if (pipe_divisor == '0) begin
        m_q[0] <= '1; m_r[0] <= pipe_dividend; m_nz[0] <= 1'b0;
      end else begin
        m_q[0] <= pipe_dividend / pipe_divisor;
        m_r[0] <= pipe_dividend % pipe_divisor;
        m_nz[0] <= 1'b1;
      end
    end
  end

  assign pipe_done      = m_go[LAT-1] | force_done;
  assign pipe_quotient  = m_q[LAT-1];
  assign pipe_remainder = m_r[LAT-1];
  assign pipe_dv_nzero  = m_nz[LAT-1];

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_ops(input int id, input logic [DDW-1:0] dd, input logic [DVW-1:0] dv);
    req_dividend[id*DDW +: DDW] = dd;
    req_divisor[id*DVW +: DVW]  = dv;
  endtask

  // Waits (bounded) for rsp_valid[id]; n = negedges waited.
  task automatic wait_rsp(input int id, output int n);
    n = 0;
    while (!rsp_valid[id] && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_seen", 64'(rsp_valid[id]), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (in_flight != '0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_flight", 64'(in_flight), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},       64'(ack), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_q"},     64'(rsp_quotient), 64'd0);
    chk({tag, "_rsp_r"},     64'(rsp_remainder), 64'd0);
    chk({tag, "_rsp_dz"},    64'(rsp_div_zero), 64'd0);
    chk({tag, "_in_flight"}, 64'(in_flight), 64'd0);
    chk({tag, "_err_tag"},   64'(err_tag), 64'd0);
    chk({tag, "_pipe_go"},   64'(pipe_go), 64'd0);
    chk({tag, "_pipe_dd"},   64'(pipe_dividend), 64'd0);
    chk({tag, "_pipe_dv"},   64'(pipe_divisor), 64'd0);
  endtask

  typedef struct {
    int             id;
    logic [DDW-1:0] dd;
    logic [DVW-1:0] dv;
    logic [QW-1:0]  q;
    logic [DDW-1:0] r;
    logic           dz;
  } vec_t;

  vec_t vt [6];

  initial begin
    int n, got, peak, early2, seen3;
    logic [QW-1:0]  q3 [4];
    logic [DDW-1:0] r3 [4];

    vt[0] = '{1, 16'd100,   8'd7,   16'd14,  16'd2,  1'b0};
    vt[1] = '{2, 16'd55,    8'd0,   16'd0,   16'd0,  1'b1};
    vt[2] = '{0, 16'd1000,  8'd33,  16'd30,  16'd10, 1'b0};
    vt[3] = '{3, 16'd65535, 8'd255, 16'd257, 16'd0,  1'b0};
    vt[4] = '{1, 16'd200,   8'd13,  16'd15,  16'd5,  1'b0};
    vt[5] = '{2, 16'd9,     8'd10,  16'd0,   16'd9,  1'b0};
    q3 = '{16'd33, 16'd27, 16'd24, 16'd21};
    r3 = '{16'd1,  16'd2,  16'd0,  16'd4};

    // Reset state
    repeat (2) @(negedge clk);
    chk_all_zero("rst");
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("post_rst");

    // All four requesting together from pointer 0
    for (int k = 0; k < N; k++) set_ops(k, DDW'(100 + 10 * k), DVW'(k + 3));
    req = 4'hf;
    peak = 0;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      if (int'(in_flight) > peak) peak = int'(in_flight);
      chk("t3_ack", 64'(ack), 64'd1 << k);
      chk("t3_pipe_dd", 64'(pipe_dividend), 64'(100 + 10 * k));
      req[k] = 1'b0;
    end
    got = 0;
    n = 0;
    while (got < N && n < 60) begin
      @(negedge clk);
      n++;
      if (int'(in_flight) > peak) peak = int'(in_flight);
      if (rsp_valid != '0) begin
        chk("t3_rsp_order", 64'(rsp_valid), 64'd1 << got);
        chk("t3_rsp_q", 64'(rsp_quotient), 64'(q3[got]));
        chk("t3_rsp_r", 64'(rsp_remainder), 64'(r3[got]));
        $display("t3 rsp %0d: q=%0d r=%0d", got, rsp_quotient, rsp_remainder);
        got++;
      end
    end
    chk("t3_rsp_count", 64'(got), 64'd4);
    chk("t3_peak", 64'(peak), 64'd4);
    drain();

    // Table-driven single-requester vectors
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      set_ops(vt[v].id, vt[v].dd, vt[v].dv);
      req[vt[v].id] = 1'b1;
      @(negedge clk);
      chk("vec_ack", 64'(ack), 64'd1 << vt[v].id);
      chk("vec_pipe_go", 64'(pipe_go), 64'd1);
      chk("vec_pipe_dd", 64'(pipe_dividend), 64'(vt[v].dd));
      chk("vec_pipe_dv", 64'(pipe_divisor), 64'(vt[v].dv));
      req[vt[v].id] = 1'b0;
      wait_rsp(vt[v].id, n);
      chk("vec_latency", 64'(n), 64'(LAT + 1));
      chk("vec_rsp_valid", 64'(rsp_valid), 64'd1 << vt[v].id);
      if (!vt[v].dz) begin
        chk("vec_q", 64'(rsp_quotient), 64'(vt[v].q));
        chk("vec_r", 64'(rsp_remainder), 64'(vt[v].r));
      end
      chk("vec_dz", 64'(rsp_div_zero), 64'(vt[v].dz));
      chk("vec_in_flight", 64'(in_flight), 64'd0);
      $display("vec %0d: req%0d %0d/%0d -> q=%0d r=%0d dz=%0d lat=%0d",
               v, vt[v].id, vt[v].dd, vt[v].dv, rsp_quotient, rsp_remainder, rsp_div_zero, n);
    end
    drain();

    // Requester 2 holds req after ack; requester 3 must get in meanwhile
    @(negedge clk);
    set_ops(2, 16'd50, 8'd5);
    req[2] = 1'b1;
    @(negedge clk);
    chk("t5_ack2", 64'(ack), 64'd4);
    @(negedge clk);
    set_ops(3, 16'd77, 8'd7);
    req[3] = 1'b1;
    n = 1;
    early2 = 0;
    seen3 = 0;
    while (!rsp_valid[2] && n < 60) begin
      @(negedge clk);
      n++;
      if (ack[3]) begin seen3 = 1; req[3] = 1'b0; end
      if (ack[2]) early2++;
    end
    chk("t5_rsp2_seen", 64'(rsp_valid[2]), 64'd1);
    chk("t5_latency", 64'(n), 64'(LAT + 1));
    chk("t5_no_regrant", 64'(early2), 64'd0);
    chk("t5_ack3_seen", 64'(seen3), 64'd1);
    chk("t5_q", 64'(rsp_quotient), 64'd10);
    @(negedge clk);
    chk("t5_regrant", 64'(ack), 64'd4);
    $display("t5: req2 regranted the cycle after its response");
    req[2] = 1'b0;
    drain();

    // Reset asserted mid-operation
    @(negedge clk);
    set_ops(0, 16'd100, 8'd7);
    req[0] = 1'b1;
    @(negedge clk);
    chk("t1_ack0", 64'(ack), 64'd1);
    req[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("t1_busy_in_flight", 64'(in_flight), 64'd1);
    #2 reset = 1'b1;
    #1 chk_all_zero("t1_midrst");
    @(negedge clk);
    reset = 1'b0;
    set_ops(1, 16'd30, 8'd4);
    req[1:0] = 2'b11;
    @(negedge clk);
    chk("t1_ptr0", 64'(ack), 64'd1);
    req[0] = 1'b0;
    @(negedge clk);
    chk("t1_next", 64'(ack), 64'd2);
    req[1] = 1'b0;
    drain();
    chk("t1_no_err", 64'(err_tag), 64'd0);
    $display("t1: mid-run reset cleared state, pointer restarted at 0");

    // pipe_done with no live tag
    @(negedge clk);
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    chk("t6_err_set", 64'(err_tag), 64'd1);
    chk("t6_no_rsp", 64'(rsp_valid), 64'd0);
    repeat (3) @(negedge clk);
    chk("t6_err_sticky", 64'(err_tag), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_err_cleared", 64'(err_tag), 64'd0);
    $display("t6: stray pipe_done flagged, sticky until reset");

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
